// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scan driver: segment
// encodings, inactive anode/segment patterns and default timing.
package seg7_pkg;

  localparam int REFRESH_DIV_DEF = 50000;
  localparam int BLANK_CYC_DEF   = 4;

  // Active-low segment pattern {g,f,e,d,c,b,a} with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low anodes with every digit switched off.
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Hex glyphs, active-low {g,f,e,d,c,b,a}; entry n sits at index n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Active-low anode pattern that lights only the selected digit.
  function automatic logic [7:0] anode_mask(input logic [2:0] digit);
    return ~(8'd1 << digit);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// data_in is captured continuously (unless held), copied to a shadow register
// only at frame boundaries so a frame never shows a torn value, and the shadow
// is scanned one nibble per digit slot with a short anode-off guard interval.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int BLANK_CYC   = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        hold,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        changed
);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [31:0] capture;
  logic [31:0] shadow;
  logic        dp_frame;

  logic        wrap;
  logic        frame_end;
  logic [31:0] upper_p0;
  logic [3:0]  nib_p0;
  logic [6:0]  glyph_p0;
  logic        lz_p0;
  logic [7:0]  an_p0;
  logic [6:0]  seg_p0;
  logic        dp_p0;

  assign wrap      = (cnt == 16'(REFRESH_DIV - 1));
  assign frame_end = wrap && (idx == 3'd7);

  // Prescaler and digit index: one slot of REFRESH_DIV cycles per digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Capture register follows data_in unless frozen by hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      capture <= '0;
    end else if (!hold) begin
      capture <= data_in;
    end
  end

  // Frame commit: shadow takes the pre-edge capture value; a differing value
  // raises changed for one cycle and lights digit 0's point for one frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow   <= '0;
      changed  <= 1'b0;
      dp_frame <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (frame_end) begin
        shadow   <= capture;
        changed  <= (capture != shadow);
        dp_frame <= (capture != shadow);
      end
    end
  end

  hex_to_seg7 u_dec (
    .nib (nib_p0),
    .seg (glyph_p0)
  );

  // Stage p0: select nibble, blanking and anode from the current scan state.
  always_comb begin
    upper_p0 = shadow >> {idx, 2'b00};
    nib_p0   = upper_p0[3:0];
    lz_p0    = blank_lz && (idx != 3'd0) && (upper_p0 == 32'd0);
    seg_p0   = lz_p0 ? SEG_BLANK : glyph_p0;
    an_p0    = (cnt < 16'(BLANK_CYC)) ? AN_OFF : anode_mask(idx);
    dp_p0    = !(dp_frame && (idx == 3'd0));
  end

  // Stage p0 -> outputs: register everything driving the display pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
// Each table record describes one 64-cycle frame window: the inputs applied
// during it and the glyphs, decimal point and change pulse it must show.
module tb_seg7_scan_driver;

  typedef logic [7:0][6:0] segs_t;

  typedef struct {
    logic [31:0] data_a;
    logic        hold_a;
    logic        lz;
    int          sw;
    logic [31:0] data_b;
    int          hsw;
    segs_t       segs;
    logic        dp0;
    logic        chg;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        hold = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        changed;

  int n_chk  = 0;
  int n_fail = 0;

  rec_t vec [16];
  rec_t post;

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .hold     (hold),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic segs_t s8(input logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic rec_t mk(input logic [31:0] data_a, input logic hold_a, input logic lz,
                              input int sw, input logic [31:0] data_b, input int hsw,
                              input segs_t segs, input logic dp0, input logic chg);
    rec_t r;
    r.data_a = data_a; r.hold_a = hold_a; r.lz = lz;
    r.sw = sw; r.data_b = data_b; r.hsw = hsw;
    r.segs = segs; r.dp0 = dp0; r.chg = chg;
    return r;
  endfunction

  task automatic run_frame(input int fno, input rec_t r);
    int slot;
    int ph;
    logic [7:0] exp_an;
    logic       exp_dp;
    logic       exp_chg;
    data_in  = r.data_a;
    hold     = r.hold_a;
    blank_lz = r.lz;
    for (int t = 0; t < 64; t++) begin
      if (t == r.sw) data_in = r.data_b;
      if (t == r.hsw) begin
        hold    = 1'b1;
        data_in = 32'h2222_2222;
      end
      tick();
      slot    = t / 8;
      ph      = t % 8;
      exp_an  = (ph < 2) ? 8'hFF : ~(8'd1 << slot);
      exp_chg = (t == 63) ? r.chg : 1'b0;
      chk($sformatf("f%0d t%0d an", fno, t), {24'd0, an}, {24'd0, exp_an});
      chk($sformatf("f%0d t%0d changed", fno, t), {31'd0, changed}, {31'd0, exp_chg});
      if (ph >= 2) begin
        exp_dp = (slot == 0) ? r.dp0 : 1'b1;
        chk($sformatf("f%0d d%0d seg", fno, slot), {25'd0, seg}, {25'd0, r.segs[slot]});
        chk($sformatf("f%0d d%0d dp", fno, slot), {31'd0, dp}, {31'd0, exp_dp});
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " an"}, {24'd0, an}, 32'hFF);
    chk({tag, " seg"}, {25'd0, seg}, 32'h7F);
    chk({tag, " dp"}, {31'd0, dp}, 32'd1);
    chk({tag, " changed"}, {31'd0, changed}, 32'd0);
  endtask

  initial begin
    segs_t z8, c1234, ca5_lz, ca5, cmix, czero_lz, ccafe, cones;
    z8       = s8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    c1234    = s8(7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
    ca5_lz   = s8(7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    ca5      = s8(7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    cmix     = s8(7'h40, 7'h40, 7'h19, 7'h40, 7'h40, 7'h30, 7'h7F, 7'h7F);
    czero_lz = s8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    ccafe    = s8(7'h30, 7'h24, 7'h79, 7'h40, 7'h06, 7'h0E, 7'h08, 7'h46);
    cones    = s8(7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79);

    //            data_a        hold lz  sw  data_b        hsw segs      dp0   chg
    vec[0]  = mk(32'h1234_5678, 0, 0, 64, 32'h0,         64, z8,       1'b1, 1'b1);
    vec[1]  = mk(32'h1234_5678, 0, 0, 64, 32'h0,         64, c1234,    1'b0, 1'b0);
    vec[2]  = mk(32'hDEAD_BEEF, 1, 0, 64, 32'h0,         64, c1234,    1'b1, 1'b0);
    vec[3]  = mk(32'hDEAD_BEEF, 1, 0, 64, 32'h0,         64, c1234,    1'b1, 1'b0);
    vec[4]  = mk(32'hDEAD_BEEF, 1, 0, 64, 32'h0,         64, c1234,    1'b1, 1'b0);
    vec[5]  = mk(32'h0000_00A5, 0, 1, 64, 32'h0,         64, c1234,    1'b1, 1'b1);
    vec[6]  = mk(32'h0000_00A5, 0, 1, 64, 32'h0,         64, ca5_lz,   1'b0, 1'b0);
    vec[7]  = mk(32'h0000_00A5, 0, 0, 64, 32'h0,         64, ca5,      1'b1, 1'b0);
    vec[8]  = mk(32'h0030_0400, 0, 1, 64, 32'h0,         64, ca5_lz,   1'b1, 1'b1);
    vec[9]  = mk(32'h0030_0400, 0, 1, 64, 32'h0,         64, cmix,     1'b0, 1'b0);
    vec[10] = mk(32'h0000_0000, 0, 1, 64, 32'h0,         64, cmix,     1'b1, 1'b1);
    vec[11] = mk(32'h0000_0000, 0, 1, 64, 32'h0,         64, czero_lz, 1'b0, 1'b0);
    vec[12] = mk(32'h0000_0000, 0, 0, 24, 32'hCAFE_0123, 64, z8,       1'b1, 1'b1);
    vec[13] = mk(32'hCAFE_0123, 0, 0, 64, 32'h0,         64, ccafe,    1'b0, 1'b0);
    vec[14] = mk(32'hCAFE_0123, 0, 0, 62, 32'h1111_1111, 63, ccafe,    1'b1, 1'b1);
    vec[15] = mk(32'h3333_3333, 1, 0, 64, 32'h0,         64, cones,    1'b0, 1'b0);
    post    = mk(32'h4444_4444, 1, 0, 64, 32'h0,         64, z8,       1'b1, 1'b0);

    // Power-on reset held for three edges.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    chk_reset_outputs("first post-reset");

    for (int f = 0; f < 16; f++) run_frame(f, vec[f]);

    // Mid-frame reset while digit 5 is lit.
    for (int i = 0; i < 43; i++) tick();
    chk("pre-reset an slot5", {24'd0, an}, 32'hDF);
    rst = 1'b0;
    tick();
    chk_reset_outputs("mid-frame reset");
    rst = 1'b1;
    run_frame(99, post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
